// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the EX stage.
// Result is computed at issue into a shadow pair and committed after a fixed latency.
module mdu_multicycle #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] out,
  output logic             div_zero
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;
  localparam logic [3:0] OP_MFHI  = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd11;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W2-1:0]   r_shadow;
  logic            r_dz_pend;
  logic            r_div_zero;
  logic            r_busy;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic            w_is_mul;
  logic            w_is_div;
  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_b_zero;
  logic [W2-1:0]   w_a_ext;
  logic [W2-1:0]   w_b_ext;
  logic [W2-1:0]   w_prod;
  logic [W2-1:0]   w_acc;
  logic [WIDTH-1:0] w_dvd;
  logic [WIDTH-1:0] w_dvs;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [W2-1:0]   w_shadow;

  // Operand decode, product and sign-magnitude divide (abs-divide avoids the MIN/-1 overflow)
  always_comb begin
    w_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    w_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    w_a_ext  = w_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    w_b_ext  = w_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    w_prod   = W2'(w_a_ext * w_b_ext);
    w_acc    = {r_hi, r_lo};
    w_a_neg  = w_signed & A[WIDTH-1];
    w_b_neg  = w_signed & B[WIDTH-1];
    w_b_zero = (B == '0);
    w_dvd    = w_a_neg ? -A : A;
    w_dvs    = w_b_neg ? -B : B;
    w_q      = w_b_zero ? '0 : (w_dvd / w_dvs);
    w_r      = w_b_zero ? '0 : (w_dvd % w_dvs);
    w_q_fix  = (w_a_neg ^ w_b_neg) ? -w_q : w_q;
    w_r_fix  = w_a_neg ? -w_r : w_r;
    case (op)
      OP_MULT, OP_MULTU: w_shadow = w_prod;
      OP_MADD, OP_MADDU: w_shadow = w_acc + w_prod;
      OP_MSUB, OP_MSUBU: w_shadow = w_acc - w_prod;
      OP_DIV, OP_DIVU:   w_shadow = w_b_zero ? w_acc : {w_r_fix, w_q_fix};
      default:           w_shadow = w_acc;
    endcase
  end

  // Issue / countdown / commit state machine
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_dz_pend  <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !cancel) begin
            if (w_is_mul || w_is_div) begin
              r_shadow  <= w_shadow;
              r_cnt     <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              r_dz_pend <= w_is_div & w_b_zero;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end else if (op == OP_MTHI) begin
              r_hi <= A;
            end else if (op == OP_MTLO) begin
              r_lo <= A;
            end
          end
        end
        S_RUN: begin
          if (cancel) begin
            r_cnt     <= '0;
            r_dz_pend <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_cnt == CW'(1)) begin
            r_hi       <= r_shadow[W2-1:WIDTH];
            r_lo       <= r_shadow[WIDTH-1:0];
            r_div_zero <= r_dz_pend;
            r_dz_pend  <= 1'b0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // MFHI/MFLO read port is combinational on op
  always_comb begin
    out = '0;
    if (op == OP_MFHI) begin
      out = r_hi;
    end else if (op == OP_MFLO) begin
      out = r_lo;
    end
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mdu_multicycle.sv
// Scoreboard bench for mdu_multicycle: expected HI/LO pushed at issue, compared at commit.
module tb_mdu_multicycle;

  localparam int MC = 5;
  localparam int DC = 10;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;
  localparam logic [3:0] OP_MFHI  = 4'd10;
  localparam logic [3:0] OP_MFLO  = 4'd11;
  localparam logic [3:0] OP_NOP   = 4'd15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] out;
  logic        div_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  mdu_multicycle #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(a), .B(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .out(out), .div_zero(div_zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model written with native signed int division
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                                        input logic [31:0] h, input logic [31:0] l, output logic dz);
    longint      sp;
    logic [63:0] up;
    logic [63:0] acc;
    int          sa;
    int          sb;
    int          q;
    int          r;
    sp  = longint'($signed(av)) * longint'($signed(bv));
    up  = {32'h0, av} * {32'h0, bv};
    acc = {h, l};
    dz  = 1'b0;
    case (o)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_MADD:  return acc + sp;
      OP_MADDU: return acc + up;
      OP_MSUB:  return acc - sp;
      OP_MSUBU: return acc - up;
      OP_DIV: begin
        if (bv == 32'h0) begin
          dz = 1'b1;
          return acc;
        end
        if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(av);
        sb = $signed(bv);
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
      end
      OP_DIVU: begin
        if (bv == 32'h0) begin
          dz = 1'b1;
          return acc;
        end
        return {av % bv, av / bv};
      end
      default: return acc;
    endcase
  endfunction

  task automatic drive_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv, input logic can);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv; cancel = can;
    @(negedge clk);
    start = 1'b0; op = OP_NOP; cancel = 1'b0;
  endtask

  // Issue an op, push its expected commit and advance the model
  task automatic issue_mdu(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
    exp_t        e;
    logic [63:0] r;
    logic        dz;
    if (o <= OP_MSUBU) begin
      r     = model(o, av, bv, m_hi, m_lo, dz);
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      e.dz  = dz;
      e.cyc = (o == OP_DIV || o == OP_DIVU) ? DC : MC;
      sb_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end else if (o == OP_MTHI) begin
      m_hi = av;
    end else if (o == OP_MTLO) begin
      m_lo = av;
    end
    drive_op(o, av, bv, 1'b0);
  endtask

  // Count busy cycles (bounded), then pop and compare the commit
  task automatic wait_done(input int already, input string tag);
    exp_t e;
    int   cyc;
    logic dz_seen;
    cyc     = already;
    dz_seen = 1'b0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (div_zero !== 1'b0) dz_seen = 1'b1;
      @(negedge clk);
    end
    check_eq({tag, " sb_depth"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq({tag, " busy_cycles"}, 64'(cyc), 64'(e.cyc));
      check_eq({tag, " hi"}, 64'(hi), 64'(e.hi));
      check_eq({tag, " lo"}, 64'(lo), 64'(e.lo));
      check_eq({tag, " div_zero_pulse"}, 64'(div_zero), 64'(e.dz));
      check_eq({tag, " div_zero_while_busy"}, 64'(dz_seen), 64'd0);
      @(negedge clk);
      check_eq({tag, " div_zero_after"}, 64'(div_zero), 64'd0);
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv, input string tag);
    issue_mdu(o, av, bv);
    wait_done(0, tag);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    reset_n = 1'b0; start = 1'b0; op = OP_MFHI; a = '0; b = '0; cancel = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst hi", 64'(hi), 64'd0);
    check_eq("rst lo", 64'(lo), 64'd0);
    check_eq("rst div_zero", 64'(div_zero), 64'd0);
    check_eq("rst out", 64'(out), 64'd0);
    reset_n = 1'b1;
    op = OP_NOP;

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    check_eq("mult_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check_eq("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7");
    check_eq("div_neg7 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check_eq("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);

    issue_mdu(OP_MTHI, 32'h0, 32'h0);
    check_eq("mthi hi", 64'(hi), 64'(m_hi));
    check_eq("mthi busy", 64'(busy), 64'd0);
    issue_mdu(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
    check_eq("mtlo lo", 64'(lo), 64'(m_lo));
    run_op(OP_MADDU, 32'd1, 32'd1, "maddu_carry");
    check_eq("maddu const", {hi, lo}, 64'h0000_0001_0000_0000);
    run_op(OP_MSUB, 32'd1, 32'd1, "msub_borrow");
    check_eq("msub const", {hi, lo}, 64'h0000_0000_FFFF_FFFF);

    issue_mdu(OP_MTHI, 32'h1234_5678, 32'h0);
    issue_mdu(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
    run_op(OP_DIVU, 32'h5555_5555, 32'h0, "divu_zero");
    check_eq("divu_zero const", {hi, lo}, 64'h1234_5678_9ABC_DEF0);

    op = OP_MFHI; #1;
    check_eq("mfhi out", 64'(out), 64'(m_hi));
    op = OP_MFLO; #1;
    check_eq("mflo out", 64'(out), 64'(m_lo));
    op = OP_NOP; #1;
    check_eq("nop out", 64'(out), 64'd0);

    // Cancel on the third busy cycle
    drive_op(OP_MULT, 32'd7, 32'd9, 1'b0);
    check_eq("cancel busy1", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_eq("cancel busy_off", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    check_eq("cancel hi", 64'(hi), 64'(m_hi));
    check_eq("cancel lo", 64'(lo), 64'(m_lo));
    check_eq("cancel div_zero", 64'(div_zero), 64'd0);

    drive_op(OP_MTLO, 32'hDEAD_BEEF, 32'h0, 1'b1);
    check_eq("mtlo_cancel lo", 64'(lo), 64'(m_lo));
    drive_op(OP_MULT, 32'd3, 32'd4, 1'b1);
    check_eq("mult_cancel busy", 64'(busy), 64'd0);

    // Start while busy must be ignored
    issue_mdu(OP_MULT, 32'hFFFF_FFF0, 32'd16);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
    wait_done(1, "start_while_busy");

    for (int i = 0; i < 10; i++) begin
      ro = 4'($urandom_range(0, 7));
      ra = $urandom();
      rb = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom();
      if (i % 3 == 0) rb = 32'(int'($urandom_range(0, 20)) - 10);
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
    end

    // Asynchronous reset in the middle of a divide
    drive_op(OP_DIV, 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst busy", 64'(busy), 64'd0);
    check_eq("midrst hi", 64'(hi), 64'd0);
    check_eq("midrst lo", 64'(lo), 64'd0);
    check_eq("midrst div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("postrst lo", 64'(lo), 64'd0);
    check_eq("postrst busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
